// File: rtl/marcador_multi_pkg.sv
// Shared definitions for the multi-player score keeper:
// FSM encoding and elaboration-time helpers.
package marcador_multi_pkg;

    typedef enum logic {
        JUEGO   = 1'b0,
        GANADOR = 1'b1
    } estado_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int k = 0; k < 32; k++) begin
            if ((1 << r) < n) r = r + 1;
        end
        return r;
    endfunction

    function automatic int id_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    function automatic bit meta_ok(input int w, input int m);
        return (m >= 1) && (m <= (1 << w) - 1);
    endfunction

    function automatic bit jug_ok(input int n);
        return (n >= 1) && (n <= 8);
    endfunction

endpackage

// File: rtl/marcador_multi_cuenta_canal.sv
// One player's channel: button/direction synchronizers, rising-edge
// detector and saturating up/down score counter.
module cuenta_canal
    import marcador_multi_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int META  = 3
) (
    input  logic             clock1k,
    input  logic             reset,
    input  logic             Modo,
    input  logic             Modificar,
    input  logic             nuevo,
    input  logic             congelar,
    output logic [WIDTH-1:0] score,
    output logic             llega
);

    localparam logic [WIDTH-1:0] META_W = WIDTH'(META);
    localparam logic [WIDTH-1:0] UNO    = WIDTH'(1);

    logic             s1_q, s2_q, prev_q;
    logic             m1_q, m2_q;
    logic             pulse;
    logic [WIDTH-1:0] score_q, score_d;

    assign pulse = s2_q & ~prev_q;

    // nuevo wins over a pulse on the same edge; frozen channels ignore pulses
    always_comb begin
        score_d = score_q;
        if (nuevo) begin
            score_d = '0;
        end else if (!congelar && pulse) begin
            if (m2_q) begin
                if (score_q < META_W) score_d = score_q + UNO;
            end else begin
                if (score_q != '0) score_d = score_q - UNO;
            end
        end
    end

    assign llega = (score_d == META_W);
    assign score = score_q;

    // Edge detector keeps running while frozen so no stale pulse survives
    always_ff @(negedge clock1k or negedge reset) begin
        if (!reset) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            prev_q  <= 1'b0;
            m1_q    <= 1'b0;
            m2_q    <= 1'b0;
            score_q <= '0;
        end else begin
            s1_q    <= Modificar;
            s2_q    <= s1_q;
            prev_q  <= s2_q;
            m1_q    <= Modo;
            m2_q    <= m1_q;
            score_q <= score_d;
        end
    end

endmodule

// File: rtl/marcador_multi.sv
// Multi-player score keeper: per-player channels plus the game FSM
// that latches the lowest-index player reaching META.
module marcador_multi
    import marcador_multi_pkg::*;
#(
    parameter int  NUM_JUG = 2,
    parameter int  WIDTH   = 2,
    parameter int  META    = 3,
    localparam int IDW     = id_width(NUM_JUG)
) (
    input  logic                       clock1k,
    input  logic                       reset,
    input  logic [NUM_JUG-1:0]         Modo,
    input  logic [NUM_JUG-1:0]         Modificar,
    input  logic                       nuevo,
    output logic [NUM_JUG*WIDTH-1:0]   counTT,
    output logic                       GanadorTT,
    output logic [IDW-1:0]             ganador_id
);

    if (!meta_ok(WIDTH, META)) begin : g_meta_err
        $error("marcador_multi: META outside 1..2^WIDTH-1");
    end
    if (!jug_ok(NUM_JUG)) begin : g_jug_err
        $error("marcador_multi: NUM_JUG outside 1..8");
    end

    estado_t            estado_q;
    logic               ganador_q;
    logic [IDW-1:0]     id_q;
    logic [IDW-1:0]     id_d;
    logic [NUM_JUG-1:0] llega;
    logic               hay;
    logic               congelar;

    assign congelar = (estado_q == GANADOR);

    for (genvar g = 0; g < NUM_JUG; g++) begin : g_canal
        cuenta_canal #(
            .WIDTH(WIDTH),
            .META (META)
        ) u_canal (
            .clock1k  (clock1k),
            .reset    (reset),
            .Modo     (Modo[g]),
            .Modificar(Modificar[g]),
            .nuevo    (nuevo),
            .congelar (congelar),
            .score    (counTT[g*WIDTH +: WIDTH]),
            .llega    (llega[g])
        );
    end

    // Lowest index wins a simultaneous arrival
    always_comb begin
        hay  = |llega;
        id_d = '0;
        for (int i = NUM_JUG - 1; i >= 0; i--) begin
            if (llega[i]) id_d = IDW'(i);
        end
    end

    always_ff @(negedge clock1k or negedge reset) begin
        if (!reset) begin
            estado_q  <= JUEGO;
            ganador_q <= 1'b0;
            id_q      <= '0;
        end else if (nuevo) begin
            estado_q  <= JUEGO;
            ganador_q <= 1'b0;
            id_q      <= '0;
        end else begin
            unique case (estado_q)
                JUEGO: begin
                    if (hay) begin
                        estado_q  <= GANADOR;
                        ganador_q <= 1'b1;
                        id_q      <= id_d;
                    end
                end
                GANADOR: begin
                    estado_q <= GANADOR;
                end
                default: begin
                    estado_q <= JUEGO;
                end
            endcase
        end
    end

    assign GanadorTT  = ganador_q;
    assign ganador_id = id_q;

endmodule
